wb_mem_bist: RTL and testbench
==============================

# wb_mem_bist

- Synthesizable Wishbone initiator: drives the application port of the SDRAM controller (`sdrc_top`) from the master side.
- Once `sdr_init_done` is high, it writes a deterministic pattern over a configured word range using incrementing bursts. It then reads the range back, compares every word and reports pass/fail, an error count and the first failing address.
- Replaces the behavioural bus driver for on-silicon and gate-level memory self-test.

## Interface

Parameters:
- `AW`, 26: Wishbone byte-address width.
- `DW`, 32: Wishbone data width; only 32 is supported.
- `BURST_LEN`, 8: maximum beats per burst, range 1..16.
- `TIMEOUT`, 1024: maximum cycles allowed without an ack while `wb_stb_o` is high.

Ports:
- `wb_clk_i`  in  1  system clock, rising edge.
- `wb_rst_i`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a test.
- `cfg_base_addr`  in  AW  start byte address; bits [1:0] are ignored and treated as 0.
- `cfg_num_words`  in  16  number of 32-bit words to test.
- `sdr_init_done`  in  1  controller initialisation complete.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1  Wishbone cycle, strobe and write-enable.
- `wb_addr_o`  out  AW  byte address.
- `wb_dat_o`  out  DW  write data.
- `wb_sel_o`  out  4  byte selects; always 4'hF while `wb_stb_o` is high.
- `wb_cti_o`  out  3  3'b010 for an incrementing beat, 3'b111 for the last beat.
- `wb_ack_i`  in  1  beat acknowledge.
- `wb_dat_i`  in  DW  read data.
- `busy`  out  1  high from start acceptance until `done` rises.
- `done`  out  1  level; high from test end until the next accepted `start`.
- `pass`  out  1  valid while `done` is high.
- `timeout`  out  1  set when the watchdog aborts the test.
- `err_cnt`  out  16  count of read mismatches; saturates at 16'hFFFF.
- `err_addr`  out  AW  byte address of the first mismatch.

## Operation

- FSM states:
  - IDLE: `start` → latch the configuration, clear the result outputs, go to WAIT_INIT.
  - WAIT_INIT: `sdr_init_done` high → WR_BURST, or DONE if `cfg_num_words`=0.
  - WR_BURST: last beat acked → WR_GAP.
  - WR_GAP: one idle cycle → WR_BURST if write words remain, else RD_BURST.
  - RD_BURST: last beat acked → RD_GAP.
  - RD_GAP: one idle cycle → RD_BURST if read words remain, else DONE.
  - DONE: `start` → WAIT_INIT, with the same latch and clear as from IDLE.
- Word index `idx` runs 0..N-1. Address = `cfg_base_addr` + 4·idx, modulo 2^AW (wraps silently).
- Pattern = {~idx[15:0], idx[15:0]}.
- Burst length = min(`BURST_LEN`, words remaining). The final burst may be shorter; a 1-word burst uses `wb_cti_o`=3'b111.
- `wb_cyc_o`/`wb_stb_o` stay high for the whole burst. A beat completes on any cycle with stb&ack. Address and data advance on the next edge; cti becomes 3'b111 for the final beat.
- Read compare happens on each ack cycle. A mismatch increments `err_cnt` (saturating) and records `err_addr` if it is the first mismatch.
- `pass` = (`err_cnt`==0) && !`timeout`.
- Watchdog counts cycles with `wb_stb_o` high and `wb_ack_i` low, and clears on ack. Reaching `TIMEOUT` sets `timeout`, drops cyc/stb the next cycle and enters DONE.
- `start` is ignored while `busy` is high.

## Timing

- Reset values of all outputs are 0; `wb_cti_o`=3'b000. The FSM resets to IDLE.
- Reset asserted mid-burst drops cyc/stb immediately (asynchronously) and discards the test.
- All outputs are registered. `start` sampled at edge k → `busy`=1 after edge k.
- With `sdr_init_done` already high, the first cyc/stb appears after edge k+1.
- The last ack of a burst is at edge m → cyc/stb low for cycle m+1 (gap) → the next burst starts after edge m+1.
- Final read ack at edge m → `err_cnt` final after edge m. `done`=1 and `busy`=0 after edge m+1.
- `cfg_num_words`=0 produces no bus activity: `done`=1 and `pass`=1 two edges after `start` (WAIT_INIT, then DONE).

## Configuration

- `WB_BIST_ERR_LOG_EN` defined: `err_addr` captures the first mismatch address and holds it until the next accepted `start`.
- Not defined: the capture register is not built, `err_addr` is tied to 0, and `err_cnt`/`pass` are unchanged.

## Test plan

- Base 0x0, 16 words, BURST_LEN 8, SDRAM model attached → two 8-beat write bursts with cti 010×7 then 111, two read bursts; `pass`=1, `err_cnt`=0.
- 11 words → bursts of 8 and 3 in each phase. The last write is at address 0x28 with data 0xFFF5000A; `pass`=1.
- Bench slave corrupts read word idx 5 (base 0x100) → `err_cnt`=1, `err_addr`=0x114 (0 without the macro), `pass`=0.
- Slave withholds ack, TIMEOUT 1024 → cyc/stb drop 1025 cycles after stb rises; `timeout`=1, `pass`=0, `done`=1.
- `cfg_num_words`=0 → no cyc. `start` pulsed mid-test → ignored; burst sequence unchanged.
- Reset pulsed during the third write beat → cyc/stb/busy go to 0 asynchronously. A new `start` re-runs from idx 0 and passes.

Source files
------------

// File: rtl/wb_mem_bist.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_mem_bist : Wishbone burst write / read-compare memory self-test       |
// | Option macro: WB_BIST_ERR_LOG_EN (first-failing-address capture)        |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module wb_mem_bist #(
  parameter int AW        = 26,
  parameter int DW        = 32,
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 1024
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          start,
  input  logic [AW-1:0] cfg_base_addr,
  input  logic [15:0]   cfg_num_words,
  input  logic          sdr_init_done,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [AW-1:0] wb_addr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic [2:0]    wb_cti_o,
  input  logic          wb_ack_i,
  input  logic [DW-1:0] wb_dat_i,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timeout,
  output logic [15:0]   err_cnt,
  output logic [AW-1:0] err_addr
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_INIT = 3'd1,
    S_WR_BURST  = 3'd2,
    S_WR_GAP    = 3'd3,
    S_RD_BURST  = 3'd4,
    S_RD_GAP    = 3'd5,
    S_DONE      = 3'd6
  } state_e;

  localparam int                  c_wdog_w   = $clog2(TIMEOUT + 1);
  localparam logic [c_wdog_w-1:0] c_wdog_max = c_wdog_w'(TIMEOUT);
  localparam logic [4:0]          c_blen     = 5'(BURST_LEN);
  localparam logic [2:0]          c_cti_inc  = 3'b010;
  localparam logic [2:0]          c_cti_end  = 3'b111;

  state_e                state_q, state_d;
  logic [AW-1:0]         base_q, base_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [15:0]           num_q, num_d;
  logic [15:0]           idx_q, idx_d;
  logic [15:0]           err_cnt_q, err_cnt_d;
  logic [4:0]            beats_q, beats_d;
  logic [c_wdog_w-1:0]   wdog_q, wdog_d;
  logic [DW-1:0]         dat_q, dat_d;
  logic [2:0]            cti_q, cti_d;
  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  timeout_q, timeout_d;

  logic                  launch;
  logic                  launch_we;

  logic                  w_accept;
  logic                  w_in_burst;
  logic                  w_wdog_exp;
  logic                  w_rd_restart;
  logic                  w_rd_miss;
  logic [15:0]           w_lidx;
  logic [15:0]           w_rem;
  logic [4:0]            w_blen;
  logic [AW-1:0]         w_laddr;

  function automatic logic [DW-1:0] f_pattern(input logic [15:0] i);
    return DW'({~i, i});
  endfunction

  assign w_accept     = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign w_in_burst   = (state_q == S_WR_BURST) || (state_q == S_RD_BURST);
  assign w_wdog_exp   = w_in_burst && (wdog_q == c_wdog_max);

  // Leaving the write phase restarts the word index at 0 for the read pass.
  assign w_rd_restart = (state_q == S_WR_GAP) && (idx_q == num_q);
  assign w_lidx       = w_rd_restart ? 16'd0 : idx_q;
  assign w_rem        = num_q - w_lidx;
  assign w_blen       = (w_rem >= 16'(BURST_LEN)) ? c_blen : w_rem[4:0];
  assign w_laddr      = base_q + AW'({w_lidx, 2'b00});

  assign w_rd_miss    = (state_q == S_RD_BURST) && cyc_q && wb_ack_i && !w_wdog_exp &&
                        (wb_dat_i != f_pattern(idx_q));

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    num_d     = num_q;
    idx_d     = idx_q;
    beats_d   = beats_q;
    wdog_d    = wdog_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    addr_d    = addr_q;
    dat_d     = dat_q;
    cti_d     = cti_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    err_cnt_d = err_cnt_q;
    launch    = 1'b0;
    launch_we = 1'b0;

    if (w_rd_miss && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          base_d    = cfg_base_addr & ~AW'(3);
          num_d     = cfg_num_words;
          idx_d     = 16'd0;
          err_cnt_d = 16'd0;
          timeout_d = 1'b0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_WAIT_INIT;
        end
      end

      S_WAIT_INIT: begin
        if (sdr_init_done) begin
          if (num_q == 16'd0) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            launch    = 1'b1;
            launch_we = 1'b1;
            state_d   = S_WR_BURST;
          end
        end
      end

      S_WR_BURST, S_RD_BURST: begin
        if (w_wdog_exp) begin
          cyc_d     = 1'b0;
          we_d      = 1'b0;
          cti_d     = 3'b000;
          dat_d     = '0;
          wdog_d    = '0;
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          pass_d    = 1'b0;
          state_d   = S_DONE;
        end else if (wb_ack_i) begin
          wdog_d = '0;
          idx_d  = idx_q + 16'd1;
          if (beats_q == 5'd1) begin
            cyc_d   = 1'b0;
            we_d    = 1'b0;
            cti_d   = 3'b000;
            dat_d   = '0;
            state_d = (state_q == S_WR_BURST) ? S_WR_GAP : S_RD_GAP;
          end else begin
            beats_d = beats_q - 5'd1;
            addr_d  = addr_q + AW'(4);
            cti_d   = (beats_q == 5'd2) ? c_cti_end : c_cti_inc;
            if (we_q) begin
              dat_d = f_pattern(idx_q + 16'd1);
            end
          end
        end else begin
          wdog_d = wdog_q + c_wdog_w'(1);
        end
      end

      S_WR_GAP: begin
        launch = 1'b1;
        if (w_rd_restart) begin
          idx_d   = 16'd0;
          state_d = S_RD_BURST;
        end else begin
          launch_we = 1'b1;
          state_d   = S_WR_BURST;
        end
      end

      S_RD_GAP: begin
        if (idx_q == num_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_cnt_q == 16'd0) && !timeout_q;
          state_d = S_DONE;
        end else begin
          launch  = 1'b1;
          state_d = S_RD_BURST;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // First beat of a burst: address/data from the launch index.
    if (launch) begin
      cyc_d   = 1'b1;
      we_d    = launch_we;
      addr_d  = w_laddr;
      dat_d   = launch_we ? f_pattern(w_lidx) : '0;
      cti_d   = (w_blen == 5'd1) ? c_cti_end : c_cti_inc;
      beats_d = w_blen;
      wdog_d  = '0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      num_q     <= '0;
      idx_q     <= '0;
      beats_q   <= '0;
      wdog_q    <= '0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      dat_q     <= '0;
      cti_q     <= 3'b000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      num_q     <= num_d;
      idx_q     <= idx_d;
      beats_q   <= beats_d;
      wdog_q    <= wdog_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      dat_q     <= dat_d;
      cti_q     <= cti_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      err_cnt_q <= err_cnt_d;
    end
  end

`ifdef WB_BIST_ERR_LOG_EN
  logic [AW-1:0] err_addr_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      err_addr_q <= '0;
    end else if (w_accept) begin
      err_addr_q <= '0;
    end else if (w_rd_miss && (err_cnt_q == 16'd0)) begin
      err_addr_q <= addr_q;
    end
  end

  assign err_addr = err_addr_q;
`else
  assign err_addr = '0;
`endif

  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_we_o   = we_q;
  assign wb_addr_o = addr_q;
  assign wb_dat_o  = dat_q;
  assign wb_sel_o  = {4{cyc_q}};
  assign wb_cti_o  = cti_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign timeout   = timeout_q;
  assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_mem_bist.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb_mem_bist : self-checking bench for wb_mem_bist with a memory slave |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_wb_mem_bist;

  localparam int AW  = 26;
  localparam int DW  = 32;
  localparam int BL  = 8;
  localparam int TMO = 1024;
`ifdef WB_BIST_ERR_LOG_EN
  localparam logic c_log = 1'b1;
`else
  localparam logic c_log = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          init_done = 1'b0;
  logic          ack = 1'b0;
  logic [AW-1:0] base = '0;
  logic [15:0]   nwords = '0;
  logic [DW-1:0] dat_i = '0;
  logic          cyc, stb, we, busy, done, pass, tmo;
  logic [AW-1:0] addr, err_addr;
  logic [DW-1:0] dat_o;
  logic [3:0]    sel;
  logic [2:0]    cti;
  logic [15:0]   err_cnt;

  always #5 clk = ~clk;

  wb_mem_bist #(.AW(AW), .DW(DW), .BURST_LEN(BL), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .start(start),
    .cfg_base_addr(base), .cfg_num_words(nwords), .sdr_init_done(init_done),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_addr_o(addr),
    .wb_dat_o(dat_o), .wb_sel_o(sel), .wb_cti_o(cti),
    .wb_ack_i(ack), .wb_dat_i(dat_i),
    .busy(busy), .done(done), .pass(pass), .timeout(tmo),
    .err_cnt(err_cnt), .err_addr(err_addr)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   dat;
    logic [2:0]    cti;
  } beat_t;

  typedef struct {
    logic [AW-1:0] base;
    int            num;
    int            mode;
    logic          cor;
    logic [AW-1:0] cor_addr;
    logic          exp_pass;
    logic [15:0]   exp_err;
    logic [AW-1:0] exp_eaddr;
    logic [AW-1:0] lw_addr;
    logic [31:0]   lw_dat;
  } vec_t;

  int            n_cmp = 0;
  int            n_bad = 0;
  beat_t         exp_q[$];
  beat_t         eb;
  logic [31:0]   mem [int];
  int            mode = 0;
  logic          cor_en = 1'b0;
  logic [AW-1:0] cor_addr = '0;
  logic          tog = 1'b0;
  logic          prev_last = 1'b0;
  int            beats = 0;
  int            stb_cycles = 0;
  logic [AW-1:0] last_wr_addr = '0;
  logic [31:0]   last_wr_dat = '0;
  vec_t          vec[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference beat sequence: writes then reads, split into bursts of at most BL.
  task automatic push_beats(input logic [AW-1:0] b_in, input int num);
    logic [AW-1:0] b;
    int            idx;
    int            blen;
    beat_t         t;
    b = b_in & ~AW'(3);
    for (int ph = 0; ph < 2; ph++) begin
      idx = 0;
      while (idx < num) begin
        blen = (num - idx < BL) ? (num - idx) : BL;
        for (int k = 0; k < blen; k++) begin
          t.we   = (ph == 0);
          t.addr = b + AW'(4 * idx);
          t.dat  = {~16'(idx), 16'(idx)};
          t.cti  = (k == blen - 1) ? 3'b111 : 3'b010;
          exp_q.push_back(t);
          idx++;
        end
      end
    end
  endtask

  // Slave memory, ack generation and beat scoreboard.
  always @(negedge clk) begin
    logic        hit;
    logic [31:0] rd;
    if (prev_last) chk("gap_stb_low", stb, 1'b0);
    prev_last = 1'b0;
    hit = rst_n && cyc && stb && ((mode == 0) || ((mode == 1) && tog));
    tog = ~tog;
    if (stb) stb_cycles++;
    ack   = hit;
    dat_i = '0;
    if (hit) begin
      beats++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got addr 0x%0h we %0b, expected no beat", addr, we);
      end else begin
        eb = exp_q.pop_front();
        chk("beat_we", we, eb.we);
        chk("beat_addr", addr, eb.addr);
        chk("beat_cti", cti, eb.cti);
        chk("beat_sel", sel, 4'hF);
        if (eb.we) chk("beat_wdat", dat_o, eb.dat);
      end
      if (we) begin
        mem[int'(addr[AW-1:2])] = dat_o;
        last_wr_addr = addr;
        last_wr_dat  = dat_o;
      end else begin
        rd = mem.exists(int'(addr[AW-1:2])) ? mem[int'(addr[AW-1:2])] : 32'h0;
        if (cor_en && (addr == cor_addr)) rd = rd ^ 32'h0000_0100;
        dat_i = rd;
      end
      prev_last = (cti == 3'b111);
    end
    if (!rst_n) prev_last = 1'b0;
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int i;
    i = 0;
    while (!done && (i < 3000)) begin
      @(negedge clk);
      i++;
    end
    chk({nm, "_done"}, done, 1'b1);
  endtask

  task automatic chk_results(input string nm, input logic ep, input logic [15:0] ee,
                             input logic [AW-1:0] ea);
    chk({nm, "_pass"}, pass, ep);
    chk({nm, "_err_cnt"}, err_cnt, ee);
    chk({nm, "_err_addr"}, err_addr, ea);
    chk({nm, "_timeout"}, tmo, 1'b0);
    chk({nm, "_busy_low"}, busy, 1'b0);
    chk({nm, "_beats_left"}, exp_q.size(), 0);
  endtask

  task automatic run_chk(input string nm, input logic ep, input logic [15:0] ee,
                         input logic [AW-1:0] ea);
    pulse_start();
    chk({nm, "_busy"}, busy, 1'b1);
    wait_done(nm);
    chk_results(nm, ep, ee, ea);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int b0;
    //                base        num mode cor cor_addr    pass err ea                    lw_addr       lw_dat
    vec[0] = '{26'h0000000, 16, 0, 1'b0, 26'h0,    1'b1, 16'd0, 26'h0,               26'h000003C, 32'hFFF0000F};
    vec[1] = '{26'h0000000, 11, 1, 1'b0, 26'h0,    1'b1, 16'd0, 26'h0,               26'h0000028, 32'hFFF5000A};
    vec[2] = '{26'h0000100, 12, 0, 1'b1, 26'h114,  1'b0, 16'd1, c_log ? 26'h114 : 26'h0,  26'h000012C, 32'hFFF4000B};
    vec[3] = '{26'h3FFFFFB,  5, 1, 1'b0, 26'h0,    1'b1, 16'd0, 26'h0,               26'h0000008, 32'hFFFB0004};
    vec[4] = '{26'h0000040,  1, 0, 1'b0, 26'h0,    1'b1, 16'd0, 26'h0,               26'h0000040, 32'hFFFF0000};
    vec[5] = '{26'h0001000, 20, 1, 1'b1, 26'h1000, 1'b0, 16'd1, c_log ? 26'h1000 : 26'h0, 26'h000104C, 32'hFFEC0013};

    repeat (3) @(negedge clk);
    chk("rst_cyc", cyc, 1'b0);
    chk("rst_stb", stb, 1'b0);
    chk("rst_cti", cti, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_err_cnt", err_cnt, 16'd0);
    rst_n = 1'b1;

    // Wait for controller initialisation before any bus activity.
    base = '0;
    nwords = 16'd16;
    push_beats(base, 16);
    pulse_start();
    repeat (5) @(negedge clk);
    chk("init_wait_stb", stb, 1'b0);
    chk("init_wait_busy", busy, 1'b1);
    init_done = 1'b1;
    wait_done("init");
    chk_results("init", 1'b1, 16'd0, '0);

    for (int i = 0; i < 6; i++) begin
      mode = vec[i].mode;
      cor_en = vec[i].cor;
      cor_addr = vec[i].cor_addr;
      base = vec[i].base;
      nwords = 16'(vec[i].num);
      last_wr_addr = '1;
      last_wr_dat = '0;
      push_beats(vec[i].base, vec[i].num);
      run_chk($sformatf("v%0d", i), vec[i].exp_pass, vec[i].exp_err, vec[i].exp_eaddr);
      chk($sformatf("v%0d_last_wr_addr", i), last_wr_addr, vec[i].lw_addr);
      chk($sformatf("v%0d_last_wr_dat", i), last_wr_dat, vec[i].lw_dat);
    end
    cor_en = 1'b0;
    mode = 0;

    // Zero words: no bus activity, done/pass two edges after start.
    nwords = 16'd0;
    stb_cycles = 0;
    pulse_start();
    chk("zero_busy", busy, 1'b1);
    chk("zero_done_early", done, 1'b0);
    @(negedge clk);
    chk("zero_done", done, 1'b1);
    chk("zero_pass", pass, 1'b1);
    chk("zero_busy_low", busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("zero_no_stb", stb_cycles, 0);

    // First strobe latency, and a start pulse mid-test that must be ignored.
    base = 26'h200;
    nwords = 16'd16;
    push_beats(base, 16);
    pulse_start();
    chk("lat_stb_k", stb, 1'b0);
    @(negedge clk);
    chk("lat_stb_k1", stb, 1'b1);
    repeat (6) @(negedge clk);
    pulse_start();
    chk("restart_ignored_busy", busy, 1'b1);
    wait_done("restart");
    chk_results("restart", 1'b1, 16'd0, '0);

    // Watchdog: slave never acks.
    mode = 2;
    base = '0;
    stb_cycles = 0;
    pulse_start();
    wait_done("tmo");
    chk("tmo_timeout", tmo, 1'b1);
    chk("tmo_pass", pass, 1'b0);
    chk("tmo_stb_cycles", stb_cycles, TMO + 1);
    chk("tmo_cyc_low", cyc, 1'b0);
    mode = 0;

    // Asynchronous reset during the third write beat, then a clean rerun.
    push_beats(26'h0, 16);
    b0 = beats;
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (beats >= b0 + 3) break;
    end
    chk("rst_mid_beats", beats - b0, 3);
    chk("rst_mid_stb_before", stb, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc", cyc, 1'b0);
    chk("rst_mid_stb", stb, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    push_beats(26'h0, 16);
    run_chk("rerun", 1'b1, 16'd0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
